// File: rtl/downcount_timer_pkg.sv
// ============================================================================
// Module  : downcount_pkg
// Brief   : Shared types and defaults for the loadable down-count timer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package downcount_pkg;

  typedef enum logic [0:0] {
    DC_IDLE = 1'b0,
    DC_RUN  = 1'b1
  } dc_state_t;

  localparam int DC_WIDTH = 4;

endpackage

`default_nettype wire

// File: rtl/downcount_timer.sv
// ============================================================================
// Module  : downcount_timer
// Brief   : Loadable down-counter with one-shot / periodic terminal-count pulse.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module downcount_timer
  import downcount_pkg::*;
#(
  parameter int WIDTH = DC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  dc_state_t        state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DC_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    if (load) begin
      count_d  = data;
      reload_d = data;
      state_d  = (data != '0) ? DC_RUN : DC_IDLE;
    end else if (state_q == DC_RUN && en) begin
      // RUN always holds a nonzero count, so the terminal test is q == 1.
      if (count_q == WIDTH'(1)) begin
        done_d = 1'b1;
        if (auto_reload) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = DC_IDLE;
        end
      end else begin
        count_d = count_q - WIDTH'(1);
      end
    end
  end

  assign q    = count_q;
  assign busy = (state_q == DC_RUN);
  assign done = done_q;
  assign zero = (count_q == '0);

endmodule

`default_nettype wire

// File: doc/downcount_timer.md
# downcount_timer

Loadable down-counter and one-shot/periodic timer. It is the counterpart of the team's loadable up-counter: the same load/data interface, counting toward zero instead of away from it. A value loaded on `data` is decremented once per enabled cycle, and a one-cycle `done` pulse fires on reaching terminal count. It optionally reloads for periodic operation. It sits beside the up-counter in the sequential library and drives timeouts and tick generation.

## Interface
- `WIDTH`, default 4: counter and data width in bits.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `load`  in  1  load `data` into counter and reload register.
- `data`  in  WIDTH  load value.
- `en`  in  1  count enable; decrement only when high.
- `auto_reload`  in  1  1 = periodic (reload on terminal count), 0 = one-shot.
- `q`  out  WIDTH  current count, registered.
- `busy`  out  1  high while in RUN, registered.
- `done`  out  1  one-cycle terminal-count pulse, registered.
- `zero`  out  1  combinational `q == 0`.

## Operation
- Reset (`rst`=1 at posedge): state IDLE, `q`=0, reload register=0, `busy`=0, `done`=0; `zero`=1. Reset overrides all other inputs.
- States:
  - IDLE: `q` holds. No decrement regardless of `en`. Never underflows.
  - RUN: decrement when `en`=1, hold when `en`=0.
- Priority at each posedge: `rst` > `load` > decrement.
- `load`=1, any state:
  - `q`←`data` and reload←`data`.
  - If `data`≠0: next state RUN.
  - If `data`=0: next state IDLE.
  - `done`=0 in both cases.
  - A load during RUN restarts the count with no `done` pulse.
- RUN, `en`=1, `q`>1: `q`←`q`−1.
- RUN, `en`=1, `q`=1 (terminal):
  - `auto_reload`=0: `q`←0, next state IDLE, `done`←1.
  - `auto_reload`=1: `q`←reload value, stay RUN, `done`←1. Period = reload value enabled cycles.
- `auto_reload` is sampled only at the terminal edge and may change mid-count.
- `done` is 1 for exactly one cycle and 0 otherwise.
- Arithmetic is unsigned WIDTH-bit. There is no wrap past 0: a decrement from 0 is impossible by construction.

## Timing
- Load latency is 1 edge: `q` shows `data` in the cycle after the `load` edge, and `busy` rises in the same cycle.
- Terminal count:
  - `done` is high in the same cycle `q` first shows 0 (one-shot) or the reload value (periodic).
  - In one-shot mode `busy` falls in that cycle.
- Load N≠0 with `en` held high: `done` asserts N cycles after the cycle in which `q`=N first appears.
- `en` low stretches the count cycle-for-cycle. `done` timing is counted in enabled cycles.
- `load` and terminal on the same edge: load wins, no `done`.
- `rst` mid-RUN: outputs take reset values after that edge. A pending terminal is discarded.

## Structure
- Package `downcount_pkg` holds:
  - state typedef `dc_state_t` with values `DC_IDLE` and `DC_RUN`;
  - default width constant `DC_WIDTH` = 4.
- Single module with no sub-module. The reload register, counter, and two-state FSM are small enough to keep together.
- All outputs are registered except `zero`.

## Test plan
- Reset, then load 3 with `en`=1 and `auto_reload`=0 → `q` = 3, 2, 1, 0. `done`=1 only in the cycle `q`=0, and `busy` falls in that cycle. `q` stays 0 for the following cycles.
- Load 2 with `auto_reload`=1 and `en`=1 → `q` = 2, 1, 2, 1, 2. `done` pulses each time `q` returns to 2. `busy` stays 1.
- Load 4, then toggle `en` as 1, 0, 0, 1, 1, 1 → `q` = 4, 3, 3, 3, 2, 1, 0. `done` appears with `q`=0 only.
- Load 5, count to 3, then load 9 → `q`=9 with no `done` and `busy` still 1. Load 1 with `en`=1 on the terminal edge → `q`=1, no `done`. Load 0 → `q`=0, `busy`=0, `done`=0.
- Load 6 and count to 4, then assert `rst` one cycle → `q`=0, `busy`=0, `done`=0, `zero`=1. Hold `en`=1 afterwards → `q` stays 0 with no underflow to 15.
- `WIDTH`=8: load 8'hFF → 255 enabled cycles later `q`=0 and `done` pulses exactly once.
